sio_sequencer: RTL and testbench

- Host-side controller for the serial core; sequences the core's single serial-out holding register from a TX FIFO.
- Collects completed receive bytes into an RX FIFO.
- Tracks framing/overrun status and raises an end-of-frame timeout.
- Sits between the CPU register interface and the serial core's Dw/AddrDw/Dr/status strobes.

---
 rtl/sio_pkg.sv | 19 +
 rtl/sio_fifo.sv | 79 +++++++
 rtl/sio_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_sio_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sio_pkg.sv
// Shared types and helpers for the serial-core host sequencer.
//   tx_state_e : TX holding-register loader states
//   DATA_W     : byte width on every data path
//   ptr_w()    : pointer width for a power-of-two FIFO depth
package sio_pkg;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LOAD   = 2'd1,
        TX_STROBE = 2'd2
    } tx_state_e;

    localparam int unsigned DATA_W = 8;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sio_fifo.sv
// Byte FIFO with same-cycle push/pop.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/data_i: write request and byte (dropped when full, unless popped too)
//   pop_i        : read request (ignored when empty)
//   data_o       : head entry, valid while !empty_o
//   full_o/empty_o: occupancy flags
// A push into an empty FIFO is only visible at data_o on the next cycle, so
// a same-cycle pop of an empty FIFO never returns the byte being pushed.
module sio_fifo
    import sio_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned      PW       = ptr_w(DEPTH);
    localparam logic [PW-1:0]    PTR_ONE  = 1;
    localparam logic [PW:0]      CNT_ONE  = 1;
    localparam logic [PW:0]      CNT_FULL = (PW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              pop_ok;
    logic              push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign data_o  = mem_q[rd_ptr_q];

    // A pop of a full FIFO frees the slot for a push in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/sio_sequencer.sv
// Host-side sequencer for the serial core.
//   clk, reset        : system clock, asynchronous active-high reset
//   en                : core-rate enable; all core-facing sampling/driving waits for it
//   tx_wr/tx_data     : CPU push into the TX FIFO; tx_full back-pressure
//   rx_rd/rx_data     : CPU pop of the RX FIFO; rx_empty flags no data
//   stat_clr          : clears the sticky ovr_err / frm_err / timeout flags
//   tx_busy           : anything still queued, held or shifting
//   ser_dw/ser_addr_dw: byte and write strobe to the core holding register
//   ser_sdo_compl/finish, ser_sdi_compl, ser_framerr, ser_dr: core status/data
//
// TX loader states:
//   state     | meaning
//   TX_IDLE   | waiting for a queued byte and an empty holding register
//   TX_LOAD   | next en: pop FIFO head onto ser_dw, raise ser_addr_dw
//   TX_STROBE | next en: drop ser_addr_dw, return to idle
module sio_sequencer
    import sio_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned TMO_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              tx_wr,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_full,
    input  logic              rx_rd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_empty,
    input  logic              stat_clr,
    output logic              ovr_err,
    output logic              frm_err,
    output logic              timeout,
    output logic              tx_busy,
    output logic [DATA_W-1:0] ser_dw,
    output logic              ser_addr_dw,
    input  logic              ser_sdo_compl,
    input  logic              ser_sdo_finish,
    input  logic              ser_sdi_compl,
    input  logic              ser_framerr,
    input  logic [DATA_W-1:0] ser_dr
);

    localparam logic [TMO_W-1:0] TMO_ONE  = 1;
    // The count that is one increment short of all-ones: the increment that
    // would reach 2^TMO_W-1 fires the timeout and rearms the counter at zero.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    // ---------------------------------------------------------------
    // Core status edge detection (sampled only on en)
    // ---------------------------------------------------------------
    logic sdo_q, sdi_q, frm_q;
    logic sdo_rise, sdi_rise, frm_rise;

    assign sdo_rise = en && ser_sdo_compl && !sdo_q;
    assign sdi_rise = en && ser_sdi_compl && !sdi_q;
    assign frm_rise = en && ser_framerr   && !frm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdo_q <= 1'b0;
            sdi_q <= 1'b0;
            frm_q <= 1'b0;
        end else if (en) begin
            sdo_q <= ser_sdo_compl;
            sdi_q <= ser_sdi_compl;
            frm_q <= ser_framerr;
        end
    end

    // ---------------------------------------------------------------
    // FIFOs
    // ---------------------------------------------------------------
    logic              tx_empty;
    logic              tx_pop;
    logic [DATA_W-1:0] tx_head;
    logic              rx_full;
    logic              rx_accept;
    logic              ovr_set;

    sio_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (tx_wr),
        .data_i  (tx_data),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    // A full RX FIFO still takes the byte when the CPU pops in the same cycle.
    assign rx_accept = sdi_rise && (!rx_full || rx_rd);
    assign ovr_set   = sdi_rise && !rx_accept;

    sio_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (rx_accept),
        .data_i  (ser_dr),
        .pop_i   (rx_rd),
        .data_o  (rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // ---------------------------------------------------------------
    // TX loader FSM
    // ---------------------------------------------------------------
    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] ser_dw_q, ser_dw_d;
    logic              addr_dw_q, addr_dw_d;
    logic              hold_empty_q, hold_empty_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= TX_IDLE;
            ser_dw_q     <= '0;
            addr_dw_q    <= 1'b0;
            hold_empty_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            ser_dw_q     <= ser_dw_d;
            addr_dw_q    <= addr_dw_d;
            hold_empty_q <= hold_empty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                TX_IDLE:   if (!tx_empty && hold_empty_q) state_d = TX_LOAD;
                TX_LOAD:   state_d = TX_STROBE;
                TX_STROBE: state_d = TX_IDLE;
                default:   state_d = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_pop       = 1'b0;
        ser_dw_d     = ser_dw_q;
        addr_dw_d    = addr_dw_q;
        hold_empty_d = hold_empty_q;
        if (sdo_rise) begin
            hold_empty_d = 1'b1;
        end
        if (en) begin
            case (state_q)
                TX_LOAD: begin
                    tx_pop       = 1'b1;
                    ser_dw_d     = tx_head;
                    addr_dw_d    = 1'b1;
                    // Placed after the sdo_rise set so a coincident edge loses.
                    hold_empty_d = 1'b0;
                end
                TX_STROBE: begin
                    addr_dw_d = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign ser_dw      = ser_dw_q;
    assign ser_addr_dw = addr_dw_q;
    assign tx_busy     = !tx_empty || !hold_empty_q || !ser_sdo_finish;

    // ---------------------------------------------------------------
    // Sticky status and receive idle timeout
    // ---------------------------------------------------------------
    logic             ovr_q, ovr_d;
    logic             frm_err_q, frm_err_d;
    logic             timeout_q, timeout_d;
    logic             tmo_arm_q, tmo_arm_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_set;

    always_comb begin
        tmo_arm_d = tmo_arm_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_set   = 1'b0;
        // Accepted and dropped bytes both count as receive activity.
        if (sdi_rise) begin
            tmo_arm_d = 1'b1;
            tmo_cnt_d = '0;
        end else if (en && tmo_arm_q) begin
            if (tmo_cnt_q == TMO_LAST) begin
                tmo_set   = 1'b1;
                tmo_arm_d = 1'b0;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_ONE;
            end
        end
    end

    // Clear first, set last: a set in the same cycle as stat_clr survives.
    always_comb begin
        ovr_d     = ovr_q;
        frm_err_d = frm_err_q;
        timeout_d = timeout_q;
        if (stat_clr) begin
            ovr_d     = 1'b0;
            frm_err_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (ovr_set)  ovr_d     = 1'b1;
        if (frm_rise) frm_err_d = 1'b1;
        if (tmo_set)  timeout_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_q     <= 1'b0;
            frm_err_q <= 1'b0;
            timeout_q <= 1'b0;
            tmo_arm_q <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            ovr_q     <= ovr_d;
            frm_err_q <= frm_err_d;
            timeout_q <= timeout_d;
            tmo_arm_q <= tmo_arm_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign ovr_err = ovr_q;
    assign frm_err = frm_err_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_sio_sequencer.sv
module tb_sio_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       rx_rd;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       stat_clr;
    logic       ovr_err;
    logic       frm_err;
    logic       timeout;
    logic       tx_busy;
    logic [7:0] ser_dw;
    logic       ser_addr_dw;
    logic       ser_sdo_compl;
    logic       ser_sdo_finish;
    logic       ser_sdi_compl;
    logic       ser_framerr;
    logic [7:0] ser_dr;

    sio_sequencer #(.TX_DEPTH(4), .RX_DEPTH(4), .TMO_W(10)) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .tx_wr          (tx_wr),
        .tx_data        (tx_data),
        .tx_full        (tx_full),
        .rx_rd          (rx_rd),
        .rx_data        (rx_data),
        .rx_empty       (rx_empty),
        .stat_clr       (stat_clr),
        .ovr_err        (ovr_err),
        .frm_err        (frm_err),
        .timeout        (timeout),
        .tx_busy        (tx_busy),
        .ser_dw         (ser_dw),
        .ser_addr_dw    (ser_addr_dw),
        .ser_sdo_compl  (ser_sdo_compl),
        .ser_sdo_finish (ser_sdo_finish),
        .ser_sdi_compl  (ser_sdi_compl),
        .ser_framerr    (ser_framerr),
        .ser_dr         (ser_dr)
    );

    always #5 clk = ~clk;

    // Log every byte the core sees written (rising ser_addr_dw).
    logic       addr_prev = 1'b0;
    logic [7:0] dw_log[$];
    always @(negedge clk) begin
        if (ser_addr_dw && !addr_prev) dw_log.push_back(ser_dw);
        addr_prev = ser_addr_dw;
    end

    typedef struct {
        bit         rst;
        bit         en;
        bit         wr;
        logic [7:0] wd;
        bit         rd;
        bit         sdi;
        logic [7:0] dr;
        bit         frm;
        bit         clr;
        bit         x_full;
        bit         x_empty;
        logic [7:0] x_data;
        bit         x_ovr;
        bit         x_frm;
    } vec_t;

    vec_t vt[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit e, input bit wr, input logic [7:0] wd,
                       input bit rd, input bit sdi, input logic [7:0] dr, input bit frm,
                       input bit clr, input bit xf, input bit xe, input logic [7:0] xd,
                       input bit xo, input bit xr);
        vec_t v;
        v.rst = rst; v.en = e; v.wr = wr; v.wd = wd; v.rd = rd; v.sdi = sdi; v.dr = dr;
        v.frm = frm; v.clr = clr; v.x_full = xf; v.x_empty = xe; v.x_data = xd;
        v.x_ovr = xo; v.x_frm = xr;
        vt.push_back(v);
    endtask

    task automatic step(input bit e);
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tx_wr = 0; tx_data = 0; rx_rd = 0; stat_clr = 0;
        ser_sdo_compl = 0; ser_sdi_compl = 0; ser_framerr = 0; ser_dr = 0;
        ser_sdo_finish = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step(0);
        reset = 0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_wr = 1; tx_data = b;
        step(0);
        tx_wr = 0;
    endtask

    task automatic wait_addr(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (ser_addr_dw) begin
                ok = 1;
                break;
            end
            step(1);
        end
    endtask

    initial begin
        logic [7:0] a_bytes[3];
        int         s0;
        bit         ok;
        bit         got;
        int         n_at;

        idle_inputs();
        en = 0;
        reset = 1;
        step(0);
        chk("reset ser_dw", ser_dw, 0);
        chk("reset ser_addr_dw", ser_addr_dw, 0);
        chk("reset tx_full", tx_full, 0);
        chk("reset rx_empty", rx_empty, 1);
        chk("reset rx_data", rx_data, 0);
        chk("reset ovr_err", ovr_err, 0);
        chk("reset frm_err", frm_err, 0);
        chk("reset timeout", timeout, 0);
        chk("reset tx_busy", tx_busy, 0);
        reset = 0;

        //  rst en wr wd     rd sdi dr    frm clr | full empty data  ovr frm
        add(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0,    0, 1, 8'h00, 0, 0);
        add(0, 0, 1, 8'h11, 0, 0, 8'h00, 0, 0,    0, 1, 8'h00, 0, 0);
        add(0, 0, 1, 8'h22, 0, 0, 8'h00, 0, 0,    0, 1, 8'h00, 0, 0);
        add(0, 0, 1, 8'h33, 0, 0, 8'h00, 0, 0,    0, 1, 8'h00, 0, 0);
        add(0, 0, 1, 8'h44, 0, 0, 8'h00, 0, 0,    1, 1, 8'h00, 0, 0);
        add(0, 0, 1, 8'h55, 0, 0, 8'h00, 0, 0,    1, 1, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0,    0, 1, 8'h00, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 8'h01, 0, 0,    0, 0, 8'h01, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0,    0, 0, 8'h01, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 8'h02, 0, 0,    0, 0, 8'h01, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0,    0, 0, 8'h01, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 8'h03, 0, 0,    0, 0, 8'h01, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0,    0, 0, 8'h01, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 8'h04, 0, 0,    0, 0, 8'h01, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0,    0, 0, 8'h01, 0, 0);
        add(0, 0, 0, 8'h00, 0, 1, 8'h99, 0, 0,    0, 0, 8'h01, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 8'h05, 0, 0,    0, 0, 8'h01, 1, 0);
        add(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0,    0, 0, 8'h01, 1, 0);
        add(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0,    0, 0, 8'h02, 1, 0);
        add(0, 1, 0, 8'h00, 0, 1, 8'h06, 0, 0,    0, 0, 8'h02, 1, 0);
        add(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0,    0, 0, 8'h02, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1,    0, 0, 8'h02, 0, 0);
        add(0, 1, 0, 8'h00, 1, 1, 8'h07, 0, 0,    0, 0, 8'h03, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 1,    0, 0, 8'h03, 0, 1);
        add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0,    0, 0, 8'h03, 0, 1);
        add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1,    0, 0, 8'h03, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0,    0, 0, 8'h03, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0,    0, 0, 8'h04, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0,    0, 0, 8'h06, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0,    0, 0, 8'h07, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0,    0, 1, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0,    0, 1, 8'h00, 0, 0);

        foreach (vt[i]) begin
            en = vt[i].en; tx_wr = vt[i].wr; tx_data = vt[i].wd; rx_rd = vt[i].rd;
            ser_sdi_compl = vt[i].sdi; ser_dr = vt[i].dr; ser_framerr = vt[i].frm;
            stat_clr = vt[i].clr; reset = vt[i].rst;
            @(posedge clk);
            #1;
            reset = 0;
            chk($sformatf("row%0d tx_full", i), tx_full, vt[i].x_full);
            chk($sformatf("row%0d rx_empty", i), rx_empty, vt[i].x_empty);
            if (!vt[i].x_empty) chk($sformatf("row%0d rx_data", i), rx_data, vt[i].x_data);
            chk($sformatf("row%0d ovr_err", i), ovr_err, vt[i].x_ovr);
            chk($sformatf("row%0d frm_err", i), frm_err, vt[i].x_frm);
        end

        // TX streaming: one strobe per byte, each after a sdo_compl pulse.
        do_reset();
        a_bytes[0] = 8'h55; a_bytes[1] = 8'hAA; a_bytes[2] = 8'h0F;
        for (int b = 0; b < 3; b++) push_tx(a_bytes[b]);
        chk("stream busy queued", tx_busy, 1);
        s0 = dw_log.size();
        for (int b = 0; b < 3; b++) begin
            ser_sdo_finish = 1;
            wait_addr(ok);
            chk($sformatf("stream strobe%0d seen", b), ok, 1);
            if (b == 2) chk("stream busy hold full", tx_busy, 1);
            ser_sdo_finish = 0;
            ser_sdo_compl = 1;
            step(1);
            ser_sdo_compl = 0;
            step(1);
        end
        chk("stream busy shifting", tx_busy, 1);
        ser_sdo_finish = 1;
        #1;
        chk("stream busy done", tx_busy, 0);
        step(1);
        chk("stream strobe count", dw_log.size() - s0, 3);
        for (int b = 0; b < 3; b++) begin
            if (dw_log.size() > s0 + b) chk($sformatf("stream byte%0d", b), dw_log[s0+b], a_bytes[b]);
        end

        // Long sdo_compl level loads exactly one further byte.
        do_reset();
        push_tx(8'hA1); push_tx(8'hB2); push_tx(8'hC3);
        s0 = dw_log.size();
        wait_addr(ok);
        chk("level first strobe", ok, 1);
        step(1);
        ser_sdo_compl = 1;
        repeat (5) step(1);
        ser_sdo_compl = 0;
        repeat (10) step(1);
        chk("level strobe count", dw_log.size() - s0, 2);
        chk("level last byte", ser_dw, 8'hB2);
        chk("level busy remaining", tx_busy, 1);

        // Receive idle timeout, with en every other clock.
        do_reset();
        ser_sdi_compl = 1; ser_dr = 8'h3C;
        step(1);
        ser_sdi_compl = 0;
        step(0);
        chk("tmo rx pushed", rx_empty, 0);
        got = 0; n_at = 0;
        for (int k = 1; k <= 1100; k++) begin
            step(1);
            step(0);
            if (timeout && !got) begin
                got = 1;
                n_at = k;
            end
        end
        chk("tmo latency", n_at, 1023);
        stat_clr = 1;
        step(0);
        stat_clr = 0;
        chk("tmo cleared", timeout, 0);

        // Asynchronous reset in the middle of a strobe.
        do_reset();
        push_tx(8'hE7);
        ser_sdi_compl = 1; ser_dr = 8'h5A; ser_framerr = 1;
        step(1);
        ser_sdi_compl = 0; ser_framerr = 0;
        step(1);
        chk("strobe pre addr_dw", ser_addr_dw, 1);
        chk("strobe pre ser_dw", ser_dw, 8'hE7);
        chk("strobe pre frm_err", frm_err, 1);
        chk("strobe pre rx_empty", rx_empty, 0);
        #2 reset = 1;
        #1;
        chk("mid reset addr_dw", ser_addr_dw, 0);
        chk("mid reset ser_dw", ser_dw, 0);
        chk("mid reset tx_full", tx_full, 0);
        chk("mid reset rx_empty", rx_empty, 1);
        chk("mid reset frm_err", frm_err, 0);
        chk("mid reset ovr_err", ovr_err, 0);
        chk("mid reset timeout", timeout, 0);
        chk("mid reset tx_busy", tx_busy, 0);
        step(0);
        reset = 0;
        step(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
